// File: rtl/fsm_pkg.sv
// fsm_pkg: shared definitions for the multicycle MIPS controller.
//   - state_t     : 4-bit state encodings, identical to those used by fsmCommand
//   - OP_*/FUNCT_*: instruction field constants
//   - ALU_*, PCSRC_*, SRCA_*, SRCB_*, REGDST_*, WBSEL_* : datapath select codes
//   - ctrl_word_t : packed datapath control word
//   - alu_op_of_funct : R-type funct to ALU operation mapping
package fsm_pkg;

  typedef enum logic [3:0] {
    STATE_IF        = 4'd0,
    STATE_ID_1      = 4'd1,
    STATE_ID_J      = 4'd2,
    STATE_ID_BNE    = 4'd3,
    STATE_EX_OP_IMM = 4'd4,
    STATE_EX_ADDI   = 4'd5,
    STATE_EX_A_OP_B = 4'd6,
    STATE_EX_A_ADD0 = 4'd7,
    STATE_EX_BNE    = 4'd8,
    STATE_MEM_READ  = 4'd9,
    STATE_MEM_WRITE = 4'd10,
    STATE_WB_XORI   = 4'd11,
    STATE_WB_LW     = 4'd12,
    STATE_WB_ALU    = 4'd13,
    STATE_WB_JAL    = 4'd14,
    STATE_WB_JR     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_TARGET = 2'd2;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd3;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] WBSEL_ALUOUT = 2'd0;
  localparam logic [1:0] WBSEL_MDR    = 2'd1;
  localparam logic [1:0] WBSEL_PC     = 2'd2;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       ab_we;
    logic       target_we;
    logic       aluout_we;
    logic       mdr_we;
    logic       mem_we;
    logic       reg_we;
    logic       iord;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
  } ctrl_word_t;

  // Unrecognised funct codes fall back to ADD.
  function automatic logic [2:0] alu_op_of_funct(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      FUNCT_ADD: op = ALU_ADD;
      FUNCT_SUB: op = ALU_SUB;
      FUNCT_SLT: op = ALU_SLT;
      default:   op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational state -> control word decode.
//   state : state whose control word is wanted
//   funct : IR[5:0], selects the ALU operation for EX_A_OP_B
//   ctrl  : control word; the BNE zero term and stall gating are applied by the caller
module control_decode
  import fsm_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] funct,
  output ctrl_word_t ctrl
);

  // Per-state control word; anything not set here stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      STATE_IF: begin
        ctrl.pc_we     = 1'b1;
        ctrl.ir_we     = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      STATE_ID_1: ctrl.ab_we = 1'b1;
      STATE_ID_J: begin
        ctrl.pc_we  = 1'b1;
        ctrl.pc_src = PCSRC_JUMP;
      end
      STATE_ID_BNE: begin
        // SRCB_SEXT here is the word-shifted branch offset
        ctrl.ab_we     = 1'b1;
        ctrl.target_we = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALU_ADD;
      end
      STATE_EX_OP_IMM: begin
        ctrl.aluout_we = 1'b1;
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_ZEXT;
        ctrl.alu_op    = ALU_XOR;
      end
      STATE_EX_ADDI: begin
        ctrl.aluout_we = 1'b1;
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALU_ADD;
      end
      STATE_EX_A_OP_B: begin
        ctrl.aluout_we = 1'b1;
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = alu_op_of_funct(funct);
      end
      STATE_EX_A_ADD0: begin
        ctrl.aluout_we = 1'b1;
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_op    = ALU_ADD;
      end
      STATE_EX_BNE: begin
        // pc_we is produced in the top from the live zero flag
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_TARGET;
      end
      STATE_MEM_READ: begin
        ctrl.iord   = 1'b1;
        ctrl.mdr_we = 1'b1;
      end
      STATE_MEM_WRITE: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_we = 1'b1;
      end
      STATE_WB_XORI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = REGDST_RT;
        ctrl.wb_sel  = WBSEL_ALUOUT;
      end
      STATE_WB_LW: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = REGDST_RT;
        ctrl.wb_sel  = WBSEL_MDR;
      end
      STATE_WB_ALU: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = REGDST_RD;
        ctrl.wb_sel  = WBSEL_ALUOUT;
      end
      STATE_WB_JAL: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = REGDST_R31;
        ctrl.wb_sel  = WBSEL_PC;
      end
      STATE_WB_JR: begin
        ctrl.pc_we  = 1'b1;
        ctrl.pc_src = PCSRC_ALUOUT;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/fsm_state_decoder.sv
// fsm_state_decoder: state register and registered Moore control word of the
// multicycle MIPS controller, with stall gating, J fixup and perf counters.
//   clk, reset (async, active high)
//   next_state, opcode, funct, zero, stall : from fsmCommand / IR / ALU / memory
//   state                 : current state, fed back to fsmCommand
//   *_we, iord, selects   : datapath control word
//   retire                : one-cycle pulse on the edge completing an instruction
//   instr_count, cycle_count : wrapping performance counters
module fsm_state_decoder
  import fsm_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         next_state,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               stall,
  output logic [3:0]         state,
  output logic               pc_we,
  output logic               ir_we,
  output logic               ab_we,
  output logic               target_we,
  output logic               aluout_we,
  output logic               mdr_we,
  output logic               mem_we,
  output logic               reg_we,
  output logic               iord,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               retire,
  output logic [COUNT_W-1:0] instr_count,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  state_t             state_r;
  state_t             eff_next_s;
  ctrl_word_t         ctrl_r;
  ctrl_word_t         next_ctrl_s;
  ctrl_word_t         reset_ctrl_s;
  logic               wr_ok_s;
  logic               bne_taken_s;
  logic               retire_s;
  logic [COUNT_W-1:0] instr_count_r;
  logic [COUNT_W-1:0] cycle_count_r;

  // J needs no further states, so return to fetch regardless of next_state.
  always_comb begin
    if (state_r == STATE_ID_J && opcode == OP_J) begin
      eff_next_s = STATE_IF;
    end else begin
      eff_next_s = state_t'(next_state);
    end
  end

  control_decode u_next_decode (
    .state (eff_next_s),
    .funct (funct),
    .ctrl  (next_ctrl_s)
  );

  // Constant IF decode used as the reset value of the control register.
  control_decode u_reset_decode (
    .state (STATE_IF),
    .funct (6'd0),
    .ctrl  (reset_ctrl_s)
  );

  // State and control word share one flop bank so they always agree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= STATE_IF;
      ctrl_r  <= reset_ctrl_s;
    end else if (!stall) begin
      state_r <= eff_next_s;
      ctrl_r  <= next_ctrl_s;
    end
  end

  // Gating, branch-taken term and retire qualification.
  always_comb begin
    wr_ok_s     = ~stall & ~reset;
    bne_taken_s = (state_r == STATE_EX_BNE) & ~zero;
    if ((state_r != STATE_IF) && (eff_next_s == STATE_IF)) begin
      retire_s = wr_ok_s;
    end else begin
      retire_s = 1'b0;
    end
  end

  // cycle_count runs through stalls; instr_count only on retiring edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count_r <= '0;
      cycle_count_r <= '0;
    end else begin
      cycle_count_r <= cycle_count_r + COUNT_ONE;
      if (retire_s) begin
        instr_count_r <= instr_count_r + COUNT_ONE;
      end
    end
  end

  assign state       = state_r;
  assign pc_we       = (ctrl_r.pc_we | bne_taken_s) & wr_ok_s;
  assign ir_we       = ctrl_r.ir_we     & wr_ok_s;
  assign ab_we       = ctrl_r.ab_we     & wr_ok_s;
  assign target_we   = ctrl_r.target_we & wr_ok_s;
  assign aluout_we   = ctrl_r.aluout_we & wr_ok_s;
  assign mdr_we      = ctrl_r.mdr_we    & wr_ok_s;
  assign mem_we      = ctrl_r.mem_we    & wr_ok_s;
  assign reg_we      = ctrl_r.reg_we    & wr_ok_s;
  assign iord        = ctrl_r.iord;
  assign alu_src_a   = ctrl_r.alu_src_a;
  assign alu_src_b   = ctrl_r.alu_src_b;
  assign alu_op      = ctrl_r.alu_op;
  assign pc_src      = ctrl_r.pc_src;
  assign reg_dst     = ctrl_r.reg_dst;
  assign wb_sel      = ctrl_r.wb_sel;
  assign retire      = retire_s;
  assign instr_count = instr_count_r;
  assign cycle_count = cycle_count_r;

endmodule
